// File: rtl/rec_sequencer.sv
// Beat-recorder session controller: debounced KEY0 start/stop, note timestamping into
// {note, tick delta} events, and arbitration of the shared recording-memory port.
module rec_sequencer #(
  parameter int TICK_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int ADDR_W       = 8,
  parameter int DELTA_W      = 16,
  parameter int NOTE_W       = 8
) (
  input  logic                      CLOCK_50,
  input  logic                      resetn,
  input  logic                      rec_key_n,
  input  logic [2:0]                sw_slot,
  input  logic                      note_valid,
  input  logic [NOTE_W-1:0]         note_code,
  input  logic                      rd_req,
  input  logic [1:0]                rd_slot,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic                      rd_gnt,
  output logic                      mem_we,
  output logic                      mem_re,
  output logic [ADDR_W+1:0]         mem_addr,
  output logic [NOTE_W+DELTA_W-1:0] mem_wdata,
  output logic [3*(ADDR_W+1)-1:0]   slot_len,
  output logic                      recording,
  output logic [1:0]                rec_slot
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LOAD  = DEB_W'(DEBOUNCE_CYC);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'((2 ** ADDR_W) - 2);

  typedef enum logic [1:0] {S_IDLE, S_REC, S_FLUSH, S_COMMIT} state_t;

  state_t                    r_state, w_state_nxt;
  logic                      r_key_s1, r_key_s2, r_key_s3;
  logic [DEB_W-1:0]          r_deb;
  logic [PRE_W-1:0]          r_pre;
  logic [DELTA_W-1:0]        r_delta;
  logic [ADDR_W-1:0]         r_addr;
  logic [1:0]                r_rec_slot;
  logic [ADDR_W:0]           r_len [3];
  logic                      r_mem_we, r_mem_re, r_rd_gnt;
  logic [ADDR_W+1:0]         r_mem_addr;
  logic [NOTE_W+DELTA_W-1:0] r_mem_wdata;

  logic       w_press, w_slot_ok, w_note, w_wr, w_start;
  logic [1:0] w_slot_dec;

  // Press is a synced falling edge outside the debounce window
  assign w_press = r_key_s3 & ~r_key_s2 & (r_deb == '0);
  assign w_note  = (r_state == S_REC) & note_valid;
  assign w_wr    = w_note | (r_state == S_FLUSH);
  assign w_start = (r_state == S_IDLE) & (w_state_nxt == S_REC);

  always_comb begin
    w_slot_ok  = 1'b1;
    w_slot_dec = 2'd0;
    case (sw_slot)
      3'b001:  w_slot_dec = 2'd0;
      3'b010:  w_slot_dec = 2'd1;
      3'b100:  w_slot_dec = 2'd2;
      default: w_slot_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_press && w_slot_ok) w_state_nxt = S_REC;
      S_REC:    if (w_press || (w_note && r_addr == ADDR_LAST)) w_state_nxt = S_FLUSH;
      S_FLUSH:  w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_key_s1 <= 1'b1;
      r_key_s2 <= 1'b1;
      r_key_s3 <= 1'b1;
      r_deb    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_key_s1 <= rec_key_n;
      r_key_s2 <= r_key_s1;
      r_key_s3 <= r_key_s2;
      if (w_press)          r_deb <= DEB_LOAD;
      else if (r_deb != '0) r_deb <= r_deb - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_pre      <= '0;
      r_delta    <= '0;
      r_addr     <= '0;
      r_rec_slot <= '0;
      for (int s = 0; s < 3; s++) r_len[s] <= '0;
    end else if (w_start) begin
      r_pre      <= '0;
      r_delta    <= '0;
      r_addr     <= '0;
      r_rec_slot <= w_slot_dec;
      for (int s = 0; s < 3; s++) if (w_slot_dec == 2'(s)) r_len[s] <= '0;
    end else if (r_state == S_REC) begin
      r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
      // A note restarts the delta even if a tick lands in the same cycle
      if (w_note) begin
        r_addr  <= r_addr + 1'b1;
        r_delta <= '0;
      end else if (r_pre == PRE_LAST && r_delta != '1) begin
        r_delta <= r_delta + 1'b1;
      end
    end else if (r_state == S_COMMIT) begin
      for (int s = 0; s < 3; s++) if (r_rec_slot == 2'(s)) r_len[s] <= {1'b0, r_addr};
    end
  end

  // Writes win the port; a read waits one cycle per write and is never granted twice
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_rd_gnt    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= w_wr;
      r_mem_re <= 1'b0;
      r_rd_gnt <= 1'b0;
      if (w_wr) begin
        r_mem_addr  <= {r_rec_slot, r_addr};
        r_mem_wdata <= {(w_note ? note_code : {NOTE_W{1'b0}}), r_delta};
      end else if (rd_req && !r_rd_gnt) begin
        r_mem_re   <= 1'b1;
        r_rd_gnt   <= 1'b1;
        r_mem_addr <= {rd_slot, rd_addr};
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign rd_gnt    = r_rd_gnt;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign slot_len  = {r_len[2], r_len[1], r_len[0]};
  assign recording = (r_state == S_REC) || (r_state == S_FLUSH);
  assign rec_slot  = r_rec_slot;

endmodule

// File: tb/tb_rec_sequencer.sv
// Directed-plus-random bench for rec_sequencer; expected memory writes and slot lengths come
// from a tick-count model of each recording session.
module tb_rec_sequencer;
  localparam int T = 4;
  localparam int DMAX = 15;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rec_key_n = 1'b1;
  logic [2:0]  sw_slot = 3'b000;
  logic        note_valid = 1'b0;
  logic [7:0]  note_code = 8'h00;
  logic        rd_req = 1'b0;
  logic [1:0]  rd_slot = 2'd0;
  logic [2:0]  rd_addr = 3'd0;
  logic        rd_gnt, mem_we, mem_re, recording;
  logic [4:0]  mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] slot_len;
  logic [1:0]  rec_slot;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gap_a[8];
  logic [7:0] code_a[8];
  int k_a[8];
  int exp_len[3];
  logic [16:0] wq[$];
  logic [16:0] eq[$];

  rec_sequencer #(.TICK_DIV(T), .DEBOUNCE_CYC(8), .ADDR_W(3), .DELTA_W(4), .NOTE_W(8)) dut (
    .CLOCK_50(clk), .resetn(resetn), .rec_key_n(rec_key_n), .sw_slot(sw_slot),
    .note_valid(note_valid), .note_code(note_code), .rd_req(rd_req), .rd_slot(rd_slot),
    .rd_addr(rd_addr), .rd_gnt(rd_gnt), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .slot_len(slot_len),
    .recording(recording), .rec_slot(rec_slot)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn) begin
      checks++;
      assert (!(mem_we && mem_re)) else begin
        errors++;
        $error("FAIL port_overlap observed we=%0b re=%0b required not both high", mem_we, mem_re);
      end
      if (mem_we) wq.push_back({mem_addr, mem_wdata});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] len_vec();
    return {exp_len[2][3:0], exp_len[1][3:0], exp_len[0][3:0]};
  endfunction

  task automatic session(input logic [2:0] sw, input int nn, input int stop_gap,
                         input bit coincide, input bit bounce, input bit rdtest);
    int slot, e0, cp, ef, kf, kl, nrec, d;
    slot = (sw == 3'b001) ? 0 : (sw == 3'b010) ? 1 : 2;
    sw_slot = sw;
    wq.delete();
    eq.delete();
    e0 = cyc + 3;
    rec_key_n = 1'b0;
    if (bounce) begin
      tick(1); rec_key_n = 1'b1; tick(1); rec_key_n = 1'b0; tick(1);
    end else begin
      tick(2); chk("rec_before_sync", recording, 0); tick(1);
    end
    chk("rec_entry", recording, 1);
    chk("rec_slot", rec_slot, slot);
    chk("len_cleared", slot_len[slot*4 +: 4], 0);
    rec_key_n = 1'b1;
    if (bounce) begin
      tick(1); rec_key_n = 1'b0; tick(1); rec_key_n = 1'b1;
    end
    sw_slot = ~sw;
    nrec = 0;
    ef = 0;
    for (int i = 0; i < nn; i++) begin
      if (coincide && i == nn - 1) begin
        cp = cyc + stop_gap;
        if (cp < e0 + 12) cp = e0 + 12;
        tick(cp - cyc);
        rec_key_n = 1'b0;
        tick(2);
      end else begin
        tick(gap_a[i]);
      end
      note_code = code_a[i];
      note_valid = 1'b1;
      if (rdtest && i == 0) begin
        rd_req = 1'b1; rd_slot = 2'(slot); rd_addr = 3'($urandom_range(0, 7));
      end
      if (nrec < 7) begin
        k_a[nrec] = cyc + 1 - e0;
        nrec++;
        if (nrec == 7) ef = cyc + 1;
      end
      tick(1);
      note_valid = 1'b0;
      if (rdtest && i == 0) begin
        chk("arb_we_first", mem_we, 1);
        chk("arb_no_gnt_yet", rd_gnt, 0);
        tick(1);
        chk("arb_re", mem_re, 1);
        chk("arb_gnt", rd_gnt, 1);
        chk("arb_rd_addr", mem_addr, {rd_slot, rd_addr});
        rd_req = 1'b0;
      end
    end
    if (nrec == 7) begin
      // auto flush already triggered by the 7th note
    end else if (coincide) begin
      ef = e0 + k_a[nrec - 1];
    end else begin
      cp = cyc + stop_gap;
      if (cp < e0 + 12) cp = e0 + 12;
      tick(cp - cyc);
      rec_key_n = 1'b0;
      ef = cp + 3;
    end
    kf = ef - e0;
    kl = (nrec > 0) ? k_a[nrec - 1] : 0;
    for (int i = 0; i < nrec; i++) begin
      d = (k_a[i] - 1) / T - ((i > 0) ? k_a[i - 1] : 0) / T;
      if (d > DMAX) d = DMAX;
      eq.push_back({2'(slot), 3'(i), code_a[i], 4'(d)});
    end
    d = kf / T - kl / T;
    if (d > DMAX) d = DMAX;
    eq.push_back({2'(slot), 3'(nrec), 8'h00, 4'(d)});
    if (cyc <= ef) begin
      tick(ef - cyc);
      chk("flush_recording", recording, 1);
    end
    if (cyc <= ef + 1) begin
      tick(ef + 1 - cyc);
      chk("recording_falls", recording, 0);
    end
    tick(3);
    rec_key_n = 1'b1;
    exp_len[slot] = nrec;
    chk("write_count", wq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < wq.size(); i++) chk("write_entry", wq[i], eq[i]);
    chk("slot_len", slot_len, len_vec());
    tick(12);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) exp_len[s] = 0;
    tick(3);
    chk("rst_recording", recording, 0);
    chk("rst_slot_len", slot_len, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_rec_slot", rec_slot, 0);
    resetn = 1'b1;
    tick(2);
    chk("idle_addr", mem_addr, 0);
    chk("idle_wdata", mem_wdata, 0);

    rd_req = 1'b1; rd_slot = 2'd2; rd_addr = 3'd5;
    tick(1);
    chk("idle_rd_re", mem_re, 1);
    chk("idle_rd_gnt", rd_gnt, 1);
    chk("idle_rd_addr", mem_addr, 5'h15);
    chk("idle_rd_we", mem_we, 0);
    rd_req = 1'b0;
    tick(1);
    chk("gnt_one_cycle", rd_gnt, 0);
    tick(4);

    // Directed: deltas of 10, 3 and 5 ticks into slot 1
    gap_a[0] = 40; gap_a[1] = 11; code_a[0] = 8'h1C; code_a[1] = 8'h1B;
    session(3'b010, 2, 16, 1'b0, 1'b0, 1'b0);

    for (int v = 0; v < 2; v++) begin
      wq.delete();
      sw_slot = (v == 0) ? 3'b011 : 3'b000;
      rec_key_n = 1'b0;
      tick(2);
      note_code = 8'h55; note_valid = 1'b1; tick(1); note_valid = 1'b0;
      tick(4);
      chk("bad_slot_idle", recording, 0);
      chk("bad_slot_no_write", wq.size(), 0);
      rec_key_n = 1'b1;
      tick(12);
    end

    for (int i = 0; i < 8; i++) begin
      gap_a[i] = $urandom_range(0, 25); code_a[i] = 8'($urandom_range(1, 255));
    end
    session(3'b001, 3, $urandom_range(1, 30), 1'b0, 1'b0, 1'b1);
    gap_a[7] = 0;
    session(3'b100, 8, 0, 1'b0, 1'b0, 1'b0);
    session(3'b001, 4, $urandom_range(1, 30), 1'b1, 1'b0, 1'b0);
    session(3'b010, 2, $urandom_range(1, 30), 1'b0, 1'b1, 1'b0);
    gap_a[0] = 70; gap_a[1] = 66;
    session(3'b001, 2, 70, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        gap_a[i] = $urandom_range(0, 30); code_a[i] = 8'($urandom_range(1, 255));
      end
      session(3'b001 << $urandom_range(0, 2), $urandom_range(0, 6), $urandom_range(1, 40),
              1'b0, 1'b0, $urandom_range(0, 1) == 1);
    end

    // Reset in the middle of a slot-2 recording
    sw_slot = 3'b100;
    rec_key_n = 1'b0;
    tick(3);
    rec_key_n = 1'b1;
    chk("pre_reset_rec", recording, 1);
    for (int i = 0; i < 2; i++) begin
      tick(5); note_code = 8'h3A; note_valid = 1'b1; tick(1); note_valid = 1'b0;
    end
    tick(2);
    #2 resetn = 1'b0;
    #1;
    chk("arst_recording", recording, 0);
    chk("arst_rec_slot", rec_slot, 0);
    chk("arst_slot_len", slot_len, 0);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_mem_addr", mem_addr, 0);
    tick(2);
    resetn = 1'b1;
    for (int s = 0; s < 3; s++) exp_len[s] = 0;
    tick(2);
    chk("post_reset_idle", recording, 0);
    chk("post_reset_len", slot_len, 0);
    tick(10);
    session(3'b100, 2, 10, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
